// File: rtl/mc_switch_allocator_pkg.sv
// Shared NoC constants: port indices and default router geometry.
package noc_pkg;

    localparam int unsigned NPORTS_DEF   = 5;
    localparam int unsigned DATASIZE_DEF = 30;

    typedef enum logic [2:0] {
        PORT_L = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_N = 3'd3,
        PORT_W = 3'd4
    } port_e;

endpackage

// File: rtl/mc_switch_allocator_if.sv
// Flit-side bundle of the switch allocator: labelled inputs and registered outputs.
interface mc_switch_allocator_if
    import noc_pkg::*;
#(
    parameter int unsigned NPORTS   = NPORTS_DEF,
    parameter int unsigned DATASIZE = DATASIZE_DEF
);

    logic [NPORTS*NPORTS-1:0]   in_label;
    logic [NPORTS*DATASIZE-1:0] in_data;
    logic [NPORTS-1:0]          in_ready;
    logic [NPORTS-1:0]          out_full;
    logic [NPORTS*DATASIZE-1:0] out_data;
    logic [NPORTS-1:0]          out_valid;

    modport master (
        output in_label, in_data, out_full,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_label, in_data, out_full,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/mc_switch_allocator_arb.sv
// Round-robin arbiter with combinational grant; the pointer moves past the winner only when en=1.
module rr_arbiter_en
    import noc_pkg::*;
#(
    parameter int unsigned N = NPORTS_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    logic          found;

    // Walk from ptr upward with explicit wrap so non-power-of-2 N needs no modulo.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        idx     = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                ptr_nxt    = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            end
            idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/mc_switch_allocator.sv
// Multicast switch allocator: per-output RR arbiters, per-input served masks, registered crossbar.
module mc_switch_allocator
    import noc_pkg::*;
#(
    parameter int unsigned NPORTS   = NPORTS_DEF,
    parameter int unsigned DATASIZE = DATASIZE_DEF
) (
    input  logic                  ua_clk,
    input  logic                  rst_n,
    mc_switch_allocator_if.slave  sw
);

    logic [NPORTS-1:0] label  [NPORTS];
    logic [NPORTS-1:0] served [NPORTS];
    logic [NPORTS-1:0] pend   [NPORTS];
    logic [NPORTS-1:0] taken  [NPORTS];
    logic [NPORTS-1:0] req    [NPORTS];
    logic [NPORTS-1:0] grant  [NPORTS];
    logic [NPORTS-1:0] done_v;

    genvar i, j;

    generate
        for (i = 0; i < NPORTS; i++) begin : g_in
            logic [NPORTS-1:0] served_q;

            assign label[i]  = sw.in_label[i*NPORTS +: NPORTS];
            assign served[i] = served_q;
            assign pend[i]   = label[i] & ~served_q;

            assign done_v[i]      = (label[i] != '0) && ((served_q | taken[i]) == label[i]);
            assign sw.in_ready[i] = (label[i] == '0) || done_v[i];

            always_ff @(posedge ua_clk or negedge rst_n) begin
                if (!rst_n) begin
                    served_q <= '0;
                end else if (done_v[i]) begin
                    served_q <= '0;
                end else begin
                    served_q <= served_q | taken[i];
                end
            end
        end

        // Requests are masked in reset so no input looks delivered before arbitration restarts.
        for (j = 0; j < NPORTS; j++) begin : g_xpose
            for (i = 0; i < NPORTS; i++) begin : g_bit
                assign req[j][i]   = pend[i][j] & rst_n;
                assign taken[i][j] = grant[j][i] & ~sw.out_full[j];
            end
        end

        for (j = 0; j < NPORTS; j++) begin : g_out
            logic                gnt_any;
            logic [DATASIZE-1:0] mux_data;
            logic                valid_q;
            logic [DATASIZE-1:0] data_q;

            rr_arbiter_en #(
                .N (NPORTS)
            ) u_arb (
                .clk   (ua_clk),
                .rst_n (rst_n),
                .req   (req[j]),
                .en    (~sw.out_full[j]),
                .grant (grant[j])
            );

            assign gnt_any = |grant[j];

            always_comb begin
                mux_data = '0;
                for (int unsigned k = 0; k < NPORTS; k++) begin
                    if (grant[j][k]) begin
                        mux_data = sw.in_data[k*DATASIZE +: DATASIZE];
                    end
                end
            end

            always_ff @(posedge ua_clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else if (!sw.out_full[j]) begin
                    valid_q <= gnt_any;
                    data_q  <= mux_data;
                end
            end

            assign sw.out_valid[j]                     = valid_q;
            assign sw.out_data[j*DATASIZE +: DATASIZE] = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_mc_switch_allocator.sv
// Directed self-checking bench for mc_switch_allocator (5 ports, 30-bit flits).
module tb_mc_switch_allocator;
    import noc_pkg::*;

    localparam int unsigned NP = 5;
    localparam int unsigned DS = 30;

    logic        ua_clk = 1'b0;
    logic        rst_n;
    int unsigned errors = 0;
    int unsigned checks = 0;
    int          exp_in [6] = '{0, 2, 4, 0, 2, 4};

    mc_switch_allocator_if #(.NPORTS(NP), .DATASIZE(DS)) sw ();

    mc_switch_allocator #(
        .NPORTS   (NP),
        .DATASIZE (DS)
    ) dut (
        .ua_clk (ua_clk),
        .rst_n  (rst_n),
        .sw     (sw)
    );

    always #5 ua_clk = ~ua_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int i, input logic [NP-1:0] lbl, input logic [DS-1:0] d);
        sw.in_label[i*NP +: NP] = lbl;
        sw.in_data[i*DS +: DS]  = d;
    endtask

    task automatic tick();
        @(posedge ua_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] od(input int j);
        return 32'(sw.out_data[j*DS +: DS]);
    endfunction

    initial begin
        sw.in_label = '0;
        sw.in_data  = '0;
        sw.out_full = '0;
        rst_n       = 1'b0;

        // Reset with a pending unicast on input 0
        set_in(0, 5'b01000, 30'h123);
        #3;
        chk("rst_valid", 32'(sw.out_valid), 32'h0);
        chk("rst_data_zero", 32'(sw.out_data != '0), 32'h0);
        chk("rst_ready", 32'(sw.in_ready), 32'(5'b11110));

        @(posedge ua_clk);
        #1;
        rst_n = 1'b1;
        settle();

        // Unicast input 0 -> output N
        chk("uni_ready", 32'(sw.in_ready), 32'(5'b11111));
        tick();
        set_in(0, 5'b00000, 30'h0);
        settle();
        chk("uni_valid", 32'(sw.out_valid), 32'(5'b01000));
        chk("uni_data", od(3), 32'h123);
        tick();
        chk("uni_idle", 32'(sw.out_valid), 32'h0);

        // Round-robin on output E among inputs 0,2,4
        set_in(0, 5'b00100, 30'h100);
        set_in(2, 5'b00100, 30'h102);
        set_in(4, 5'b00100, 30'h104);
        settle();
        for (int k = 0; k < 6; k++) begin
            chk("rr_ready", 32'(sw.in_ready), 32'(5'b01010 | 5'(1 << exp_in[k])));
            tick();
            if (k == 5) begin
                set_in(0, 5'b00000, 30'h0);
                set_in(2, 5'b00000, 30'h0);
                set_in(4, 5'b00000, 30'h0);
            end
            settle();
            chk("rr_valid", 32'(sw.out_valid), 32'(5'b00100));
            chk("rr_data", od(2), 32'h100 + 32'(exp_in[k]));
        end
        tick();
        chk("rr_idle", 32'(sw.out_valid), 32'h0);

        // Backpressure on output E while it holds 3FF
        set_in(0, 5'b00100, 30'h3FF);
        settle();
        tick();
        chk("bp_first_valid", 32'(sw.out_valid), 32'(5'b00100));
        chk("bp_first_data", od(2), 32'h3FF);
        sw.out_full = 5'b00100;
        set_in(0, 5'b00100, 30'h200);
        set_in(2, 5'b00100, 30'h222);
        settle();
        chk("bp_ready_blocked", 32'(sw.in_ready), 32'(5'b11010));
        tick();
        tick();
        chk("bp_hold_valid", 32'(sw.out_valid), 32'(5'b00100));
        chk("bp_hold_data", od(2), 32'h3FF);
        sw.out_full = 5'b00000;
        settle();
        chk("bp_ptr_kept", 32'(sw.in_ready), 32'(5'b11110));
        tick();
        set_in(2, 5'b00000, 30'h0);
        settle();
        chk("bp_next_data", od(2), 32'h222);
        tick();
        set_in(0, 5'b00000, 30'h0);
        settle();
        chk("bp_last_data", od(2), 32'h200);
        tick();
        chk("bp_idle", 32'(sw.out_valid), 32'h0);

        // Multicast input 1 -> S,E,W with W full for 3 cycles
        sw.out_full = 5'b10000;
        set_in(1, 5'b10110, 30'h0AB);
        settle();
        chk("mc_ready_wait", 32'(sw.in_ready), 32'(5'b11101));
        tick();
        chk("mc_part_valid", 32'(sw.out_valid), 32'(5'b00110));
        chk("mc_part_data1", od(1), 32'h0AB);
        chk("mc_part_data2", od(2), 32'h0AB);
        chk("mc_part_ready", 32'(sw.in_ready), 32'(5'b11101));
        tick();
        chk("mc_nodup1", 32'(sw.out_valid), 32'h0);
        tick();
        chk("mc_nodup2", 32'(sw.out_valid), 32'h0);
        chk("mc_still_wait", 32'(sw.in_ready), 32'(5'b11101));
        sw.out_full = 5'b00000;
        settle();
        chk("mc_ready_final", 32'(sw.in_ready), 32'(5'b11111));
        tick();
        set_in(1, 5'b00000, 30'h0);
        settle();
        chk("mc_last_valid", 32'(sw.out_valid), 32'(5'b10000));
        chk("mc_last_data", od(4), 32'h0AB);
        tick();
        chk("mc_idle", 32'(sw.out_valid), 32'h0);

        // Async reset between multicast branches
        sw.out_full = 5'b10000;
        set_in(1, 5'b10110, 30'h5A5);
        settle();
        tick();
        chk("ar_part_valid", 32'(sw.out_valid), 32'(5'b00110));
        chk("ar_part_data", od(1), 32'h5A5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_clr", 32'(sw.out_valid), 32'h0);
        chk("ar_data_clr", 32'(sw.out_data != '0), 32'h0);
        chk("ar_ready_rst", 32'(sw.in_ready), 32'(5'b11101));
        sw.out_full = 5'b00000;
        tick();
        chk("ar_valid_in_rst", 32'(sw.out_valid), 32'h0);
        rst_n = 1'b1;
        settle();
        chk("ar_ready_resume", 32'(sw.in_ready), 32'(5'b11111));
        tick();
        set_in(1, 5'b00000, 30'h0);
        settle();
        chk("ar_resend_valid", 32'(sw.out_valid), 32'(5'b10110));
        chk("ar_resend_d1", od(1), 32'h5A5);
        chk("ar_resend_d2", od(2), 32'h5A5);
        chk("ar_resend_d4", od(4), 32'h5A5);
        tick();
        chk("ar_idle", 32'(sw.out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
